// File: rtl/tx_pkg.sv
// Shared constants and parser state type for the OFDM transmit front end.
package tx_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  CFG_OPCODE     = 8'h20;
    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam int          HDR_BYTES      = 42;   // eth 14 + IPv4 20 + UDP 8
    localparam int          SAMPLE_W       = 17;   // {last, 16-bit sample}

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HDR,
        S_PAYLOAD,
        S_DROP
    } parse_state_t;

endpackage

// File: rtl/tx_sample_fifo.sv
// Synchronous sample FIFO with a registered output stage. Occupancy (and so
// "full") counts the output register too, so the FIFO holds exactly 2**AW
// entries in total.
module tx_sample_fifo #(
    parameter int AW = 10,
    parameter int W  = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   occ;
    logic          empty;
    logic          load;

    assign empty = (cnt == '0);
    assign occ   = cnt + {{AW{1'b0}}, rd_valid};
    assign full  = (occ == (AW+1)'(DEPTH));
    // Refill the output register whenever it is empty or being consumed.
    assign load  = !empty && (!rd_valid || rd_ready);

    // Storage array write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointers, count and the registered output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (load)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, load};
            if (load) begin
                rd_valid <= 1'b1;
                rd_data  <= mem[rd_ptr];
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tx_top.sv
// Transmit front end: parses Ethernet/IPv4/UDP frames addressed to this node,
// applies config packets to the frame length, and packs data payloads into
// big-endian 16-bit samples streamed out through the sample FIFO.
module tx_top
    import tx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h112233445566,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80180,
    parameter logic [15:0] LOCAL_PORT = 16'd1234,
    parameter int          FIFO_AW    = 10,
    parameter logic [15:0] FRAME_LEN0 = 16'd256
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        dac_valid,
    input  logic        dac_ready,
    output logic [15:0] dac_payload_fragment,
    output logic        dac_payload_last,
    output logic        rx_overflow,
    output logic [15:0] frame_len
);

    parse_state_t        state;
    logic                rx_valid_q;
    logic [5:0]          hdr_cnt;
    logic                mac_uc_ok, mac_bc_ok;
    logic [7:0]          len_hi, cfg_hi, hold_byte;
    logic [15:0]         pay_len, pay_cnt, smp_cnt;
    logic                is_cfg;
    logic                wr_en;
    logic [15:0]         wr_data;

    logic [7:0]          mac_exp;
    logic                uc_next, bc_next, hdr_bad;
    logic                cur_cfg, pay_last, cfg_fire;
    logic                fifo_full, fifo_push, sample_drop;
    logic [SAMPLE_W-1:0] fifo_din, fifo_dout;

    // Header byte checks for the current header position
    always_comb begin
        mac_exp = 8'h00;
        case (hdr_cnt)
            6'd0:    mac_exp = LOCAL_MAC[47:40];
            6'd1:    mac_exp = LOCAL_MAC[39:32];
            6'd2:    mac_exp = LOCAL_MAC[31:24];
            6'd3:    mac_exp = LOCAL_MAC[23:16];
            6'd4:    mac_exp = LOCAL_MAC[15:8];
            6'd5:    mac_exp = LOCAL_MAC[7:0];
            default: mac_exp = 8'h00;
        endcase
        uc_next = mac_uc_ok && (rx_data == mac_exp);
        bc_next = mac_bc_ok && (rx_data == 8'hFF);
        hdr_bad = 1'b0;
        case (hdr_cnt)
            6'd5:    hdr_bad = !(uc_next || bc_next);
            6'd12:   hdr_bad = rx_data != ETHERTYPE_IPV4[15:8];
            6'd13:   hdr_bad = rx_data != ETHERTYPE_IPV4[7:0];
            6'd14:   hdr_bad = rx_data != IP_VER_IHL;
            6'd23:   hdr_bad = rx_data != IP_PROTO_UDP;
            6'd30:   hdr_bad = rx_data != LOCAL_IP[31:24];
            6'd31:   hdr_bad = rx_data != LOCAL_IP[23:16];
            6'd32:   hdr_bad = rx_data != LOCAL_IP[15:8];
            6'd33:   hdr_bad = rx_data != LOCAL_IP[7:0];
            6'd36:   hdr_bad = rx_data != LOCAL_PORT[15:8];
            6'd37:   hdr_bad = rx_data != LOCAL_PORT[7:0];
            6'd39:   hdr_bad = {len_hi, rx_data} <= 16'd8;  // empty or bogus UDP length
            default: hdr_bad = 1'b0;
        endcase
    end

    // The packet type is decided on the first payload byte, then held in is_cfg.
    assign cur_cfg  = (pay_cnt == 16'd0) ? ((pay_len == 16'd3) && (rx_data == CFG_OPCODE)) : is_cfg;
    assign pay_last = (pay_cnt == pay_len - 16'd1);
    assign cfg_fire = (state == S_PAYLOAD) && rx_valid && is_cfg && (pay_cnt == 16'd2)
                      && ({cfg_hi, rx_data} != 16'd0);

    // Parser and packer: walks each frame, emits registered sample writes and config updates
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            // Start as "already high" so a frame in flight at reset is ignored.
            rx_valid_q <= 1'b1;
            hdr_cnt    <= '0;
            mac_uc_ok  <= 1'b0;
            mac_bc_ok  <= 1'b0;
            len_hi     <= '0;
            cfg_hi     <= '0;
            hold_byte  <= '0;
            pay_len    <= '0;
            pay_cnt    <= '0;
            is_cfg     <= 1'b0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            frame_len  <= FRAME_LEN0;
        end else begin
            rx_valid_q <= rx_valid;
            wr_en      <= 1'b0;
            if (!rx_valid) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (!rx_valid_q) state <= S_PREAMBLE;
                    S_PREAMBLE: begin
                        if (rx_data == SFD_BYTE) begin
                            state     <= S_HDR;
                            hdr_cnt   <= '0;
                            mac_uc_ok <= 1'b1;
                            mac_bc_ok <= 1'b1;
                        end else if (rx_data != PREAMBLE_BYTE) begin
                            state <= S_DROP;
                        end
                    end
                    S_HDR: begin
                        hdr_cnt   <= hdr_cnt + 6'd1;
                        mac_uc_ok <= uc_next;
                        mac_bc_ok <= bc_next;
                        if (hdr_cnt == 6'd38) len_hi  <= rx_data;
                        if (hdr_cnt == 6'd39) pay_len <= {len_hi, rx_data} - 16'd8;
                        if (hdr_bad) begin
                            state <= S_DROP;
                        end else if (hdr_cnt == 6'(HDR_BYTES - 1)) begin
                            state   <= S_PAYLOAD;
                            pay_cnt <= '0;
                        end
                    end
                    S_PAYLOAD: begin
                        pay_cnt <= pay_cnt + 16'd1;
                        if (pay_cnt == 16'd0) is_cfg <= cur_cfg;
                        if (cur_cfg) begin
                            if (pay_cnt == 16'd1) cfg_hi <= rx_data;
                            if (cfg_fire) frame_len <= {cfg_hi, rx_data};
                        end else if (!pay_cnt[0]) begin
                            hold_byte <= rx_data;
                            if (pay_last) begin
                                wr_en   <= 1'b1;
                                wr_data <= {rx_data, 8'h00};
                            end
                        end else begin
                            wr_en   <= 1'b1;
                            wr_data <= {hold_byte, rx_data};
                        end
                        if (pay_last) state <= S_DROP;
                    end
                    S_DROP:  state <= S_DROP;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // A write into a full FIFO still lands if the output is draining that cycle.
    assign sample_drop = wr_en && fifo_full && !(dac_valid && dac_ready);
    assign fifo_push   = wr_en && !sample_drop;
    assign fifo_din    = {(smp_cnt == frame_len - 16'd1), wr_data};

    // Framer: tags frame-last at write time and tracks the sticky overflow flag
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            smp_cnt     <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (sample_drop) rx_overflow <= 1'b1;
            if (cfg_fire) smp_cnt <= '0;
            else if (fifo_push) smp_cnt <= fifo_din[16] ? 16'd0 : smp_cnt + 16'd1;
        end
    end

    tx_sample_fifo #(
        .AW (FIFO_AW),
        .W  (SAMPLE_W)
    ) u_fifo (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .wr_en    (fifo_push),
        .wr_data  (fifo_din),
        .full     (fifo_full),
        .rd_valid (dac_valid),
        .rd_ready (dac_ready),
        .rd_data  (fifo_dout)
    );

    assign dac_payload_fragment = fifo_dout[15:0];
    assign dac_payload_last     = fifo_dout[16];

endmodule

// File: tb/tb_tx_top.sv
// Self-checking bench for tx_top: a default instance for the main scenarios and
// a FIFO_AW=4 instance for overflow and mid-frame reset.
module tb_tx_top;

    localparam logic [47:0] LMAC  = 48'h112233445566;
    localparam logic [31:0] LIP   = 32'hC0A80180;
    localparam logic [15:0] LPORT = 16'd1234;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_b, sel_b;
    logic        rx_valid, rx_valid_a, rx_valid_b;
    logic [7:0]  rx_data;
    logic        ready_a, valid_a, last_a, ovf_a;
    logic        ready_b, valid_b, last_b, ovf_b;
    logic [15:0] frag_a, flen_a, frag_b, flen_b;

    assign rx_valid_a = rx_valid & ~sel_b;
    assign rx_valid_b = rx_valid & sel_b;

    tx_top dut (
        .sys_clk(clk), .sys_rst(rst), .rx_valid(rx_valid_a), .rx_data(rx_data),
        .dac_valid(valid_a), .dac_ready(ready_a), .dac_payload_fragment(frag_a),
        .dac_payload_last(last_a), .rx_overflow(ovf_a), .frame_len(flen_a)
    );

    tx_top #(.FIFO_AW(4)) dut_b (
        .sys_clk(clk), .sys_rst(rst_b), .rx_valid(rx_valid_b), .rx_data(rx_data),
        .dac_valid(valid_b), .dac_ready(ready_b), .dac_payload_fragment(frag_b),
        .dac_payload_last(last_b), .rx_overflow(ovf_b), .frame_len(flen_b)
    );

    int errors = 0;
    int checks = 0;
    int cnt_m, flen_m;
    int valid_cycles_a = 0;
    logic [7:0]  pay[$];
    logic [16:0] exp_q[$], got_q[$], exp_b[$], got_b[$];

    // Collect transfers away from the active edge (inputs change at posedge+1)
    always @(negedge clk) begin
        if (valid_a) valid_cycles_a++;
        if (valid_a && ready_a) got_q.push_back({last_a, frag_a});
        if (valid_b && ready_b) got_b.push_back({last_b, frag_b});
    end

    task automatic set_ramp(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'(i));
    endtask

    // Reference model of config/data handling and the frame-last counter
    task automatic model_accept();
        logic [15:0] v;
        logic [7:0]  lo;
        logic        lst;
        if (pay.size() == 3 && pay[0] == 8'h20) begin
            v = {pay[1], pay[2]};
            if (v != 16'd0) begin
                flen_m = int'(v);
                cnt_m  = 0;
            end
        end else begin
            for (int k = 0; k < pay.size(); k += 2) begin
                lo  = (k + 1 < pay.size()) ? pay[k+1] : 8'h00;
                lst = (cnt_m == flen_m - 1);
                exp_q.push_back({lst, pay[k], lo});
                cnt_m = lst ? 0 : cnt_m + 1;
            end
        end
    endtask

    task automatic send_frame(input logic [47:0] mac, input logic [15:0] et, input logic [31:0] ip,
                              input logic [15:0] port, input int rst_at);
        logic [7:0]  f[$];
        logic [15:0] ulen, tlen;
        ulen = 16'(pay.size() + 8);
        tlen = ulen + 16'd20;
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) f.push_back(mac[8*i +: 8]);
        f.push_back(8'h02); f.push_back(8'h00); f.push_back(8'h00);
        f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h01);
        f.push_back(et[15:8]); f.push_back(et[7:0]);
        f.push_back(8'h45); f.push_back(8'h00); f.push_back(tlen[15:8]); f.push_back(tlen[7:0]);
        f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h40); f.push_back(8'h00);
        f.push_back(8'h40); f.push_back(8'h11); f.push_back(8'h00); f.push_back(8'h00);
        f.push_back(8'hC0); f.push_back(8'hA8); f.push_back(8'h01); f.push_back(8'h0A);
        for (int i = 3; i >= 0; i--) f.push_back(ip[8*i +: 8]);
        f.push_back(8'h04); f.push_back(8'h00); f.push_back(port[15:8]); f.push_back(port[7:0]);
        f.push_back(ulen[15:8]); f.push_back(ulen[7:0]); f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 0; i < pay.size(); i++) f.push_back(pay[i]);
        f.push_back(8'hDE); f.push_back(8'hAD); f.push_back(8'hBE); f.push_back(8'hEF);
        for (int i = 0; i < f.size(); i++) begin
            rx_valid = 1'b1;
            rx_data  = f[i];
            if (i == rst_at) begin
                rst_b = 1'b1;
                #2;
                checks++;
                if (valid_b !== 1'b0 || frag_b !== 16'h0000 || last_b !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_outputs got valid=%b frag=%h last=%b exp 0/0000/0",
                             valid_b, frag_b, last_b);
                end
                checks++;
                if (ovf_b !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_overflow got=%b exp=0", ovf_b);
                end
                checks++;
                if (flen_b !== 16'd256) begin
                    errors++;
                    $display("FAIL midrst_frame_len got=%h exp=0100", flen_b);
                end
                rst_b = 1'b0;
            end
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Bounded wait until the collected queue has caught up, then idle to expose extras
    task automatic wait_drain(input bit b);
        for (int c = 0; c < 5000; c++) begin
            if (b ? (got_b.size() >= exp_b.size()) : (got_q.size() >= exp_q.size())) break;
            @(posedge clk); #1;
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        checks++;
        if (frag_a !== 16'h0000) begin errors++; $display("FAIL reset_fragment got=%h exp=0000", frag_a); end
        checks++;
        if (last_a !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", last_a); end
        checks++;
        if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", ovf_a); end
        checks++;
        if (flen_a !== 16'd256) begin errors++; $display("FAIL reset_frame_len got=%h exp=0100", flen_a); end
        rst = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_data(input string name, input int n);
        logic [16:0] g, e;
        ready_a = 1'b1;
        set_ramp(n);
        model_accept();
        send_frame(LMAC, 16'h0800, LIP, LPORT, -1);
        wait_drain(1'b0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL %s_sample got=%h exp=%h", name, g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_config(input logic [15:0] v, input logic [15:0] exp_len);
        pay.delete();
        pay.push_back(8'h20); pay.push_back(v[15:8]); pay.push_back(v[7:0]);
        model_accept();
        send_frame(LMAC, 16'h0800, LIP, LPORT, -1);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL config_samples got=%0d exp=0", got_q.size()); end
        checks++;
        if (flen_a !== exp_len) begin errors++; $display("FAIL config_frame_len got=%h exp=%h", flen_a, exp_len); end
        got_q.delete();
    endtask

    task automatic test_filter();
        int v0;
        set_ramp(16);
        for (int k = 0; k < 4; k++) begin
            v0 = valid_cycles_a;
            case (k)
                0:       send_frame(LMAC, 16'h0806, LIP, LPORT, -1);
                1:       send_frame(LMAC, 16'h0800, LIP, 16'd1235, -1);
                2:       send_frame(LMAC, 16'h0800, 32'hC0A80181, LPORT, -1);
                default: send_frame(48'h112233445567, 16'h0800, LIP, LPORT, -1);
            endcase
            repeat (10) @(posedge clk);
            #1;
            checks++;
            if (valid_cycles_a != v0 || got_q.size() != 0) begin
                errors++;
                $display("FAIL filter_%0d got valid_cycles=%0d samples=%0d exp 0/0", k, valid_cycles_a - v0, got_q.size());
            end
            got_q.delete();
        end
    endtask

    task automatic test_broadcast();
        logic [16:0] g, e;
        pay.delete();
        pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h33); pay.push_back(8'h44);
        model_accept();
        send_frame(48'hFFFFFFFFFFFF, 16'h0800, LIP, LPORT, -1);
        wait_drain(1'b0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bcast_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL bcast_sample got=%h exp=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_hold();
        logic [16:0] g, e;
        ready_a = 1'b0;
        pay.delete();
        pay.push_back(8'h00); pay.push_back(8'h01); pay.push_back(8'h02);
        model_accept();
        send_frame(LMAC, 16'h0800, LIP, LPORT, -1);
        for (int c = 0; c < 50 && !valid_a; c++) begin @(posedge clk); #1; end
        e = exp_q[0];
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (valid_a !== 1'b1 || frag_a !== e[15:0] || last_a !== e[16]) begin
                errors++;
                $display("FAIL hold_cycle%0d got valid=%b frag=%h exp valid=1 frag=%h", c, valid_a, frag_a, e[15:0]);
            end
            @(posedge clk); #1;
        end
        ready_a = 1'b1;
        wait_drain(1'b0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL hold_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL hold_sample got=%h exp=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        logic [16:0] g, e;
        sel_b = 1'b1;
        ready_b = 1'b0;
        set_ramp(512);
        send_frame(LMAC, 16'h0800, LIP, LPORT, -1);
        checks++;
        if (ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf_b); end
        for (int k = 0; k < 16; k++) exp_b.push_back({1'b0, 8'(2*k), 8'(2*k+1)});
        ready_b = 1'b1;
        wait_drain(1'b1);
        checks++;
        if (got_b.size() != exp_b.size()) begin
            errors++;
            $display("FAIL ovf_count got=%0d exp=%0d", got_b.size(), exp_b.size());
        end
        while (got_b.size() > 0 && exp_b.size() > 0) begin
            g = got_b.pop_front();
            e = exp_b.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL ovf_sample got=%h exp=%h", g, e); end
        end
        checks++;
        if (ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_b); end
        got_b.delete(); exp_b.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [16:0] g, e;
        ready_b = 1'b0;
        set_ramp(64);
        send_frame(LMAC, 16'h0800, LIP, LPORT, 8 + 42 + 20);
        ready_b = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (got_b.size() != 0 || valid_b !== 1'b0) begin
            errors++;
            $display("FAIL midrst_leftover got samples=%0d valid=%b exp 0/0", got_b.size(), valid_b);
        end
        got_b.delete();
        pay.delete();
        for (int i = 0; i < 6; i++) pay.push_back(8'(8'hA0 + i));
        exp_b.push_back({1'b0, 16'hA0A1});
        exp_b.push_back({1'b0, 16'hA2A3});
        exp_b.push_back({1'b0, 16'hA4A5});
        send_frame(LMAC, 16'h0800, LIP, LPORT, -1);
        wait_drain(1'b1);
        checks++;
        if (got_b.size() != exp_b.size()) begin
            errors++;
            $display("FAIL postrst_count got=%0d exp=%0d", got_b.size(), exp_b.size());
        end
        while (got_b.size() > 0 && exp_b.size() > 0) begin
            g = got_b.pop_front();
            e = exp_b.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL postrst_sample got=%h exp=%h", g, e); end
        end
        got_b.delete(); exp_b.delete();
        sel_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1; sel_b = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00;
        ready_a = 1'b0; ready_b = 1'b0;
        cnt_m = 0; flen_m = 256;
        test_reset();
        test_data("data512", 512);
        test_data("data64", 64);
        test_config(16'h0110, 16'h0110);
        test_data("data544", 544);
        test_config(16'h0000, 16'h0110);
        test_filter();
        test_broadcast();
        test_hold();
        test_overflow();
        test_reset_mid_frame();
        checks++;
        if (ovf_a !== 1'b0) begin errors++; $display("FAIL main_overflow got=%b exp=0", ovf_a); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
